pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game sequencer for the VGA pong design. It gates the ball datapath, commands serves, keeps both scores and a rally-based speed level, and declares a winner. It sits between the paddle/ball logic, which reports hits and misses, and the pixel generator, which consumes scores, blink and game-over. All timing is counted in frames.

## Interface

Parameters:
- WIN_SCORE, 9: points needed to win; must be 1..2^SCORE_W-1.
- SCORE_W, 4: score register width.
- SERVE_FRAMES, 60: frames the ball is held before a serve; must be ≥1.
- POINT_FRAMES, 30: frames of score flash after a point; must be ≥1.
- RALLY_STEP, 4: paddle hits per speed increment; must be ≥1.

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: reset, synchronous, active-high. Clock is clk.
- frame_tick, in, 1: one-cycle pulse once per frame, at the start of vertical blanking.
- start, in, 1: start button level, already synchronised to clk.
- hit_l / hit_r, in, 1 each: one-cycle pulse when the ball bounces off the left/right paddle.
- miss_l / miss_r, in, 1 each: one-cycle pulse when the ball passes the left/right paddle.
- state, out, 3: encoding IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- ball_run, out, 1: ball logic may move the ball; high only in PLAY.
- serve_req, out, 1: one-cycle pulse telling the ball logic to reposition at the serve_side paddle.
- serve_side, out, 1: 0 means the left side serves; 1 means the right side serves.
- score_l / score_r, out, SCORE_W each: current scores.
- speed, out, 2: ball speed level, 0..3.
- blink, out, 1: score flash enable.
- game_over, out, 1: high in OVER.
- winner, out, 1: 0 means left won; 1 means right won. Valid while game_over is high.

## Operation

- All outputs are registers or decodes of registered state. There is no combinational path from any input to any output.
- Reset values:
  - state IDLE.
  - scores 0, speed 0, rally count 0, frame-delay counter 0, free frame counter 0.
  - serve_side 1, winner 0.
  - serve_req, ball_run, blink and game_over all 0.
  - start_q (start edge register) resets to 1, so a button held through reset does not start a game.
- Start edge: `start & ~start_q`. It is acted on only in IDLE and OVER and ignored in every other state.
- IDLE: on a start edge, clear scores, speed, rally count and winner, set serve_side=1, load the delay counter with SERVE_FRAMES-1, and go to SERVE.
- SERVE:
  - On frame_tick with counter≠0, decrement the counter.
  - On frame_tick with counter=0, go to PLAY and pulse serve_req in the first PLAY cycle.
- PLAY:
  - Each hit_l/hit_r increments the rally count.
  - When the rally count reaches RALLY_STEP, it clears and speed increments, saturating at 3.
  - miss_l: score_r+1, serve_side=1. miss_r: score_l+1, serve_side=0.
  - On either miss, rally count and speed clear.
  - If the new score equals WIN_SCORE, go to OVER with winner set to the scorer.
  - Otherwise load the counter with POINT_FRAMES-1 and go to POINT.
- POINT: same countdown rule as SERVE. On expiry, load SERVE_FRAMES-1 and go to SERVE.
- OVER: scores and winner are held. On a start edge, behave exactly as IDLE's start.
- Free frame counter: 4 bits, increments on every frame_tick in all states and wraps. blink = counter[3] in POINT or OVER, else 0.
- Priorities and edge cases:
  - miss_l and miss_r in the same cycle: miss_l wins and miss_r is dropped.
  - A miss in the same cycle as a hit: the miss wins and the hit is not counted.
  - hit and miss pulses outside PLAY are ignored.
  - Scores never exceed WIN_SCORE.

## Timing

- State and all outputs update on the clk edge after the qualifying input cycle (1-cycle latency).
- A frame_tick in the same cycle as a state entry is not counted. SERVE therefore exits on the SERVE_FRAMES-th frame_tick after entry, and POINT on the POINT_FRAMES-th.
- serve_req is high for exactly one cycle, coincident with the first cycle where state=PLAY and ball_run=1.
- A miss in the first PLAY cycle is honoured.
- rst mid-operation: every register takes its reset value on the next edge, overriding all inputs.

## Test plan

- Reset with start held high for 5 cycles then kept high: state stays IDLE. Release then press start: state=SERVE the next cycle, serve_side=1.
- SERVE_FRAMES=3: after start, issue 3 frame_ticks. State becomes PLAY after the 3rd; serve_req is high for exactly 1 cycle; ball_run=1.
- In PLAY, 4 hits: speed=1. 16 hits: speed=3, and it stays 3 on further hits. miss_r: score_l=1, serve_side=0, speed=0, state=POINT, blink follows frame counter bit 3.
- miss_l and hit_r in the same cycle: score_r increments and the rally count is unchanged (still 0 after the clear). miss_l and miss_r together: only score_r increments.
- WIN_SCORE=2: two miss_l events in PLAY. Second gives score_r=2, state=OVER, game_over=1, winner=1. A start edge then clears scores and enters SERVE.
- Assert rst in PLAY with score_l=3 and speed=2: the next cycle has all outputs at reset values and state=IDLE.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/point/over flow, scoring, rally-based speed
// and score flash, all paced in video frames.
module pong_game_ctrl #(
   parameter int WIN_SCORE    = 9,
   parameter int SCORE_W      = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30,
   parameter int RALLY_STEP   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               hit_l,
   input  logic               hit_r,
   input  logic               miss_l,
   input  logic               miss_r,
   output logic [2:0]         state,
   output logic               ball_run,
   output logic               serve_req,
   output logic               serve_side,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic [1:0]         speed,
   output logic               blink,
   output logic               game_over,
   output logic               winner
);

   localparam int DLY_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
   localparam int RALLY_W = $clog2(RALLY_STEP + 1);

   localparam logic [DLY_W-1:0]   SERVE_LOAD = DLY_W'(SERVE_FRAMES - 1);
   localparam logic [DLY_W-1:0]   POINT_LOAD = DLY_W'(POINT_FRAMES - 1);
   localparam logic [RALLY_W-1:0] RALLY_LAST = RALLY_W'(RALLY_STEP - 1);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t             st;
   logic [DLY_W-1:0]   dly;
   logic [RALLY_W-1:0] rally;
   logic [3:0]         fcnt;
   logic               start_q;
   logic               start_edge;
   logic [SCORE_W-1:0] sl_nxt;
   logic [SCORE_W-1:0] sr_nxt;

   function automatic logic [1:0] speed_inc(input logic [1:0] s);
      return (s == 2'd3) ? s : s + 2'd1;
   endfunction

   assign start_edge = start & ~start_q;
   assign sl_nxt     = score_l + SCORE_W'(1);
   assign sr_nxt     = score_r + SCORE_W'(1);

   assign state     = st;
   assign ball_run  = (st == S_PLAY);
   assign game_over = (st == S_OVER);
   assign blink     = fcnt[3] & ((st == S_POINT) | (st == S_OVER));

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= S_IDLE;
         score_l    <= '0;
         score_r    <= '0;
         speed      <= '0;
         rally      <= '0;
         dly        <= '0;
         fcnt       <= '0;
         serve_side <= 1'b1;
         winner     <= 1'b0;
         serve_req  <= 1'b0;
         start_q    <= 1'b1;
      end else begin
         start_q   <= start;
         serve_req <= 1'b0;
         if (frame_tick) fcnt <= fcnt + 4'd1;

         case (st)
            S_IDLE, S_OVER: begin
               if (start_edge) begin
                  score_l    <= '0;
                  score_r    <= '0;
                  speed      <= '0;
                  rally      <= '0;
                  winner     <= 1'b0;
                  serve_side <= 1'b1;
                  dly        <= SERVE_LOAD;
                  st         <= S_SERVE;
               end
            end
            S_SERVE: begin
               if (frame_tick) begin
                  if (dly != '0) dly <= dly - DLY_W'(1);
                  else begin
                     st        <= S_PLAY;
                     serve_req <= 1'b1;
                  end
               end
            end
            S_PLAY: begin
               // miss_l outranks miss_r, and any miss swallows a same-cycle hit
               if (miss_l) begin
                  score_r    <= sr_nxt;
                  serve_side <= 1'b1;
                  rally      <= '0;
                  speed      <= '0;
                  if (sr_nxt == WIN) begin
                     st     <= S_OVER;
                     winner <= 1'b1;
                  end else begin
                     dly <= POINT_LOAD;
                     st  <= S_POINT;
                  end
               end else if (miss_r) begin
                  score_l    <= sl_nxt;
                  serve_side <= 1'b0;
                  rally      <= '0;
                  speed      <= '0;
                  if (sl_nxt == WIN) begin
                     st     <= S_OVER;
                     winner <= 1'b0;
                  end else begin
                     dly <= POINT_LOAD;
                     st  <= S_POINT;
                  end
               end else if (hit_l | hit_r) begin
                  if (rally == RALLY_LAST) begin
                     rally <= '0;
                     speed <= speed_inc(speed);
                  end else begin
                     rally <= rally + RALLY_W'(1);
                  end
               end
            end
            S_POINT: begin
               if (frame_tick) begin
                  if (dly != '0) dly <= dly - DLY_W'(1);
                  else begin
                     dly <= SERVE_LOAD;
                     st  <= S_SERVE;
                  end
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed vector table, hand-written game sequences
// and randomized play checked against a frame/score-level reference model.
module tb_pong_game_ctrl;

   localparam int WIN_SCORE    = 5;
   localparam int SCORE_W      = 4;
   localparam int SERVE_FRAMES = 3;
   localparam int POINT_FRAMES = 2;
   localparam int RALLY_STEP   = 4;

   logic               clk = 1'b0;
   logic               rst, frame_tick, start, hit_l, hit_r, miss_l, miss_r;
   logic [2:0]         state;
   logic               ball_run, serve_req, serve_side, blink, game_over, winner;
   logic [SCORE_W-1:0] score_l, score_r;
   logic [1:0]         speed;

   int n_cmp = 0;
   int n_bad = 0;

   pong_game_ctrl #(
      .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W), .SERVE_FRAMES(SERVE_FRAMES),
      .POINT_FRAMES(POINT_FRAMES), .RALLY_STEP(RALLY_STEP)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
      .hit_l(hit_l), .hit_r(hit_r), .miss_l(miss_l), .miss_r(miss_r),
      .state(state), .ball_run(ball_run), .serve_req(serve_req),
      .serve_side(serve_side), .score_l(score_l), .score_r(score_r),
      .speed(speed), .blink(blink), .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   // Reference model: game mode (0 idle,1 serve,2 play,3 point,4 over),
   // frames still to wait, total hits in the current rally, ticks seen mod 16.
   int m_mode, m_sl, m_sr, m_hits, m_left, m_frames, m_side, m_winner, m_req, m_sprev;

   function automatic int m_speed();
      int s = m_hits / RALLY_STEP;
      return (s > 3) ? 3 : s;
   endfunction

   task automatic model_step(input bit r, st, ft, hl, hr, ml, mr);
      bit edge_s;
      if (r) begin
         m_mode = 0; m_sl = 0; m_sr = 0; m_hits = 0; m_left = 0; m_frames = 0;
         m_side = 1; m_winner = 0; m_req = 0; m_sprev = 1;
         return;
      end
      edge_s  = st && !m_sprev;
      m_sprev = st;
      m_req   = 0;
      if (ft) m_frames = (m_frames + 1) % 16;
      case (m_mode)
         0, 4: if (edge_s) begin
            m_sl = 0; m_sr = 0; m_hits = 0; m_winner = 0; m_side = 1;
            m_left = SERVE_FRAMES; m_mode = 1;
         end
         1: if (ft) begin
            m_left--;
            if (m_left == 0) begin m_mode = 2; m_req = 1; end
         end
         2: if (ml || mr) begin
            if (ml) begin m_sr++; m_side = 1; end
            else    begin m_sl++; m_side = 0; end
            m_hits = 0;
            if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) begin
               m_mode = 4; m_winner = ml ? 1 : 0;
            end else begin
               m_mode = 3; m_left = POINT_FRAMES;
            end
         end else if (hl || hr) m_hits++;
         3: if (ft) begin
            m_left--;
            if (m_left == 0) begin m_mode = 1; m_left = SERVE_FRAMES; end
         end
         default: m_mode = 0;
      endcase
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int blink_exp = ((m_mode == 3 || m_mode == 4) && m_frames >= 8) ? 1 : 0;
      chk("model_state",      int'(state),      m_mode);
      chk("model_ball_run",   int'(ball_run),   (m_mode == 2) ? 1 : 0);
      chk("model_serve_req",  int'(serve_req),  m_req);
      chk("model_serve_side", int'(serve_side), m_side);
      chk("model_score_l",    int'(score_l),    m_sl);
      chk("model_score_r",    int'(score_r),    m_sr);
      chk("model_speed",      int'(speed),      m_speed());
      chk("model_blink",      int'(blink),      blink_exp);
      chk("model_game_over",  int'(game_over),  (m_mode == 4) ? 1 : 0);
      chk("model_winner",     int'(winner),     m_winner);
   endtask

   task automatic step(input bit r, st, ft, hl, hr, ml, mr);
      @(negedge clk);
      rst = r; start = st; frame_tick = ft; hit_l = hl; hit_r = hr; miss_l = ml; miss_r = mr;
      @(posedge clk);
      #1;
      model_step(r, st, ft, hl, hr, ml, mr);
      check_model();
   endtask

   task automatic goto_play();
      int n = 0;
      while (state != 3'd2 && n < 40) begin
         step(0, 0, 1, 0, 0, 0, 0);
         n++;
      end
      chk("goto_play_reached", int'(state), 2);
   endtask

   typedef struct {
      bit r, st, ft, hl, hr, ml, mr;
      int e_state, e_sl, e_sr, e_spd, e_side, e_req;
   } vec_t;

   function automatic vec_t mk(input bit r, st, ft, hl, hr, ml, mr,
                               input int es, esl, esr, espd, eside, ereq);
      vec_t v;
      v.r = r; v.st = st; v.ft = ft; v.hl = hl; v.hr = hr; v.ml = ml; v.mr = mr;
      v.e_state = es; v.e_sl = esl; v.e_sr = esr; v.e_spd = espd; v.e_side = eside; v.e_req = ereq;
      return v;
   endfunction

   initial begin
      vec_t tbl[$];
      rst = 1'b1; start = 1'b1; frame_tick = 1'b0;
      hit_l = 1'b0; hit_r = 1'b0; miss_l = 1'b0; miss_r = 1'b0;

      // r st ft hl hr ml mr ; state sl sr spd side req
      for (int i = 0; i < 5; i++) tbl.push_back(mk(1,1,0,0,0,0,0, 0,0,0,0,1,0));
      tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0,1,0));  // start held through reset
      tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,1,0));
      tbl.push_back(mk(0,1,0,0,0,0,0, 1,0,0,0,1,0));  // press -> SERVE
      tbl.push_back(mk(0,0,1,0,0,0,0, 1,0,0,0,1,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 1,0,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,1,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 2,0,0,0,1,1));  // 3rd tick -> PLAY + serve_req
      tbl.push_back(mk(0,0,0,0,0,0,0, 2,0,0,0,1,0));
      tbl.push_back(mk(0,0,0,1,0,0,0, 2,0,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,1,0,0, 2,0,0,0,1,0));
      tbl.push_back(mk(0,0,0,1,0,0,0, 2,0,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,1,0,0, 2,0,0,1,1,0));  // 4th hit -> speed 1
      tbl.push_back(mk(0,0,0,0,0,0,1, 3,1,0,0,0,0));  // miss_r
      tbl.push_back(mk(0,0,1,0,0,0,0, 3,1,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 1,1,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 1,1,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 1,1,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 2,1,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1,1,0, 3,1,1,0,1,0));  // miss_l+hit_r in first PLAY cycle
      tbl.push_back(mk(0,0,1,0,0,0,0, 3,1,1,0,1,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 1,1,1,0,1,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 1,1,1,0,1,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 1,1,1,0,1,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 2,1,1,0,1,1));
      tbl.push_back(mk(0,0,0,0,1,0,0, 2,1,1,0,1,0));  // 3 hits: hit with miss was not counted
      tbl.push_back(mk(0,0,0,0,1,0,0, 2,1,1,0,1,0));
      tbl.push_back(mk(0,0,0,0,1,0,0, 2,1,1,0,1,0));
      tbl.push_back(mk(0,0,0,1,0,0,0, 2,1,1,1,1,0));
      tbl.push_back(mk(0,0,0,0,0,1,1, 3,1,2,0,1,0));  // both misses: only score_r
      tbl.push_back(mk(0,0,1,1,0,0,1, 3,1,2,0,1,0));  // hit/miss ignored in POINT
      tbl.push_back(mk(0,0,1,0,0,0,0, 1,1,2,0,1,0));

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].st, tbl[i].ft, tbl[i].hl, tbl[i].hr, tbl[i].ml, tbl[i].mr);
         chk($sformatf("vec%0d_state", i),      int'(state),      tbl[i].e_state);
         chk($sformatf("vec%0d_score_l", i),    int'(score_l),    tbl[i].e_sl);
         chk($sformatf("vec%0d_score_r", i),    int'(score_r),    tbl[i].e_sr);
         chk($sformatf("vec%0d_speed", i),      int'(speed),      tbl[i].e_spd);
         chk($sformatf("vec%0d_serve_side", i), int'(serve_side), tbl[i].e_side);
         chk($sformatf("vec%0d_serve_req", i),  int'(serve_req),  tbl[i].e_req);
      end

      // Speed saturation, then build score_l=3 / speed=2 and reset mid-PLAY
      goto_play();
      for (int i = 1; i <= 19; i++) begin
         step(0, 0, 0, 1, 0, 0, 0);
         if (i == 4)  chk("sat_speed_after4",  int'(speed), 1);
         if (i == 16) chk("sat_speed_after16", int'(speed), 3);
      end
      chk("sat_speed_after19", int'(speed), 3);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("sat_miss_r_score_l", int'(score_l), 2);
      chk("sat_miss_r_speed", int'(speed), 0);
      goto_play();
      step(0, 0, 0, 0, 0, 0, 1);
      goto_play();
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0, 0);
      chk("pre_rst_score_l", int'(score_l), 3);
      chk("pre_rst_speed", int'(speed), 2);
      step(1, 0, 1, 1, 0, 1, 0);
      chk("rst_state", int'(state), 0);
      chk("rst_score_l", int'(score_l), 0);
      chk("rst_speed", int'(speed), 0);
      chk("rst_ball_run", int'(ball_run), 0);
      chk("rst_serve_side", int'(serve_side), 1);
      chk("rst_serve_req", int'(serve_req), 0);
      chk("rst_game_over", int'(game_over), 0);

      // Play a full game to OVER, then restart
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("restart_state", int'(state), 1);
      for (int k = 0; k < WIN_SCORE; k++) begin
         goto_play();
         step(0, 0, 0, 0, 0, 1, 0);
      end
      chk("over_state", int'(state), 4);
      chk("over_game_over", int'(game_over), 1);
      chk("over_winner", int'(winner), 1);
      chk("over_score_r", int'(score_r), WIN_SCORE);
      for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0, 1, 1);
      chk("over_hold_score_r", int'(score_r), WIN_SCORE);
      chk("over_hold_state", int'(state), 4);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("over_start_state", int'(state), 1);
      chk("over_start_score_r", int'(score_r), 0);
      chk("over_start_winner", int'(winner), 0);

      // Randomized play against the model
      for (int c = 0; c < 4000; c++) begin
         int h = $urandom % 12;
         step(($urandom % 900) == 0, ($urandom % 10) < 2, ($urandom % 4) == 0,
              h == 0, h == 1, ($urandom % 22) == 0, ($urandom % 22) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
